// File: rtl/dma_job_scheduler_if.sv
// Custom-instruction (CI) bus used on both sides of the DMA job scheduler.
// master drives a command; slave answers with done/result.
interface dma_job_scheduler_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (output start, ciN, valueA, valueB, input done, result);
  modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/dma_job_scheduler.sv
// CI job queue that programs, launches and polls a DMA CI block on the CPU's behalf.
// Optional macro DMA_SCHED_IRQ_EN adds an irq port pulsing once per completed job.
module dma_job_scheduler #(
  parameter logic [7:0] customId = 8'h00,
  parameter logic [7:0] dmaCiId  = 8'h00,
  parameter int         DEPTH    = 4
) (
  input  logic                clock,
  input  logic                reset,
  dma_job_scheduler_if.slave  cpu,
  dma_job_scheduler_if.master dma
`ifdef DMA_SCHED_IRQ_EN
  ,
  output logic                irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] bus;
    logic [8:0]  mem;
    logic [9:0]  blk;
    logic [7:0]  burst;
    logic        dir;
  } job_t;

  typedef struct packed {
    logic        start;
    logic [31:0] va;
    logic [31:0] vb;
  } dma_out_t;

  typedef enum logic [2:0] {
    IDLE, W_BUS, W_MEM, W_BLK, W_BURST, W_CTRL, SETTLE, POLL
  } state_e;

  state_e      state_r;
  job_t        job_r;
  dma_out_t    dma_out_r;
  logic [1:0]  settle_r;
  logic [31:0] stg_bus_r;
  logic [8:0]  stg_mem_r;
  logic [9:0]  stg_blk_r;
  logic [7:0]  stg_burst_r;
  job_t        fifo_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] fifo_cnt_r;
  logic [7:0]  cmp_cnt_r;
  logic [7:0]  err_cnt_r;
  logic        last_err_r;

  logic        active_s;
  logic [3:0]  op_s;
  logic        push_ok_s;
  logic        pop_s;
  logic        flush_s;
  logic        clr_s;
  logic        comp_s;
  logic        comp_ok_s;
  logic        comp_err_s;
  job_t        head_s;
  logic [31:0] status_s;
  logic        unused_s;

  function automatic logic [31:0] va_f(input logic [2:0] sel, input logic wr);
    return {19'd0, sel, wr, 9'd0};
  endfunction

  // Downstream CI drive for a given state; IDLE and SETTLE leave the port quiet.
  function automatic dma_out_t drive_f(input state_e s, input job_t j);
    dma_out_t o;
    o = {65{1'b0}};
    case (s)
      W_BUS:   o = {1'b1, va_f(3'd1, 1'b1), j.bus};
      W_MEM:   o = {1'b1, va_f(3'd2, 1'b1), 23'd0, j.mem};
      W_BLK:   o = {1'b1, va_f(3'd3, 1'b1), 22'd0, j.blk};
      W_BURST: o = {1'b1, va_f(3'd4, 1'b1), 24'd0, j.burst};
      W_CTRL:  o = {1'b1, va_f(3'd5, 1'b1), 30'd0, j.dir, ~j.dir};
      POLL:    o = {1'b1, va_f(3'd5, 1'b0), 32'd0};
      default: o = {65{1'b0}};
    endcase
    return o;
  endfunction

  assign active_s   = cpu.start & (cpu.ciN == customId);
  assign op_s       = cpu.valueA[3:0];
  assign push_ok_s  = active_s & (op_s == 4'd4) & (fifo_cnt_r != CW'(DEPTH)) & (stg_blk_r != 10'd0);
  assign clr_s      = active_s & (op_s == 4'd6);
  assign flush_s    = active_s & (op_s == 4'd7);
  assign pop_s      = (state_r == IDLE) & (fifo_cnt_r != {CW{1'b0}});
  assign comp_s     = (state_r == POLL) & dma.done & ~dma.result[0];
  assign comp_ok_s  = comp_s & ~dma.result[1];
  assign comp_err_s = comp_s & dma.result[1];
  assign head_s     = fifo_mem_r[rd_ptr_r];
  assign status_s   = {7'd0, last_err_r, err_cnt_r, cmp_cnt_r, 7'(fifo_cnt_r), (state_r != IDLE)};
  assign unused_s   = ^{cpu.valueA[31:4], dma.result[31:2]};

  assign dma.start  = dma_out_r.start;
  assign dma.ciN    = dmaCiId;
  assign dma.valueA = dma_out_r.va;
  assign dma.valueB = dma_out_r.vb;

  // Upstream answers in the same cycle it is addressed.
  always_comb begin
    cpu.done   = active_s;
    cpu.result = 32'd0;
    if (active_s) begin
      case (op_s)
        4'd4:    cpu.result = {31'd0, push_ok_s};
        4'd5:    cpu.result = status_s;
        default: cpu.result = 32'd0;
      endcase
    end else begin
      cpu.result = 32'd0;
    end
  end

  // Staging registers; they survive a push so repeated pushes reuse them.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stg_bus_r   <= 32'd0;
      stg_mem_r   <= 9'd0;
      stg_blk_r   <= 10'd0;
      stg_burst_r <= 8'd0;
    end else if (active_s) begin
      case (op_s)
        4'd0:    stg_bus_r   <= cpu.valueB;
        4'd1:    stg_mem_r   <= cpu.valueB[8:0];
        4'd2:    stg_blk_r   <= cpu.valueB[9:0];
        4'd3:    stg_burst_r <= cpu.valueB[7:0];
        default: stg_bus_r   <= stg_bus_r;
      endcase
    end
  end

  // Job storage.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= {stg_bus_r, stg_mem_r, stg_blk_r, stg_burst_r, cpu.valueB[0]};
    end
  end

  // Queue pointers; a flush drops everything not already popped this cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_cnt_r <= {CW{1'b0}};
    end else if (flush_s) begin
      rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
      wr_ptr_r   <= rd_ptr_r + AW'(pop_s);
      fifo_cnt_r <= {CW{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_r + AW'(push_ok_s);
      rd_ptr_r   <= rd_ptr_r + AW'(pop_s);
      fifo_cnt_r <= fifo_cnt_r + CW'(push_ok_s) - CW'(pop_s);
    end
  end

  // Job sequencer; downstream outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r   <= IDLE;
      job_r     <= {60{1'b0}};
      settle_r  <= 2'd0;
      dma_out_r <= {65{1'b0}};
    end else begin
      case (state_r)
        IDLE: if (pop_s) begin
          job_r     <= head_s;
          state_r   <= W_BUS;
          dma_out_r <= drive_f(W_BUS, head_s);
        end
        W_BUS: if (dma.done) begin
          state_r   <= W_MEM;
          dma_out_r <= drive_f(W_MEM, job_r);
        end
        W_MEM: if (dma.done) begin
          state_r   <= W_BLK;
          dma_out_r <= drive_f(W_BLK, job_r);
        end
        W_BLK: if (dma.done) begin
          state_r   <= W_BURST;
          dma_out_r <= drive_f(W_BURST, job_r);
        end
        W_BURST: if (dma.done) begin
          state_r   <= W_CTRL;
          dma_out_r <= drive_f(W_CTRL, job_r);
        end
        W_CTRL: if (dma.done) begin
          state_r   <= SETTLE;
          settle_r  <= 2'd0;
          dma_out_r <= drive_f(SETTLE, job_r);
        end
        SETTLE: if (settle_r == 2'd2) begin
          state_r   <= POLL;
          dma_out_r <= drive_f(POLL, job_r);
        end else begin
          settle_r  <= settle_r + 2'd1;
        end
        POLL: if (comp_s) begin
          state_r   <= IDLE;
          dma_out_r <= drive_f(IDLE, job_r);
        end
        default: begin
          state_r   <= IDLE;
          dma_out_r <= {65{1'b0}};
        end
      endcase
    end
  end

  // Completion statistics; a clear in the completion cycle lands before the increment.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cmp_cnt_r  <= 8'd0;
      err_cnt_r  <= 8'd0;
      last_err_r <= 1'b0;
    end else begin
      cmp_cnt_r <= (clr_s ? 8'd0 : cmp_cnt_r) + {7'd0, comp_ok_s};
      err_cnt_r <= (clr_s ? 8'd0 : err_cnt_r) + {7'd0, comp_err_s};
      if (comp_s) begin
        last_err_r <= dma.result[1];
      end else if (clr_s) begin
        last_err_r <= 1'b0;
      end
    end
  end

`ifdef DMA_SCHED_IRQ_EN
  logic irq_r;

  // One-cycle pulse following each completion.
  always_ff @(posedge clock) begin
    if (!reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= comp_s;
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_dma_job_scheduler.sv
// Scoreboard bench for dma_job_scheduler: expected CI results and DMA register
// writes are queued at stimulus time and checked by a negedge monitor.
module tb_dma_job_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dma_job_scheduler_if cpu_bus ();
  dma_job_scheduler_if dma_bus ();
`ifdef DMA_SCHED_IRQ_EN
  logic irq;
`endif

  dma_job_scheduler #(.customId(8'h00), .dmaCiId(8'h00), .DEPTH(4)) dut (
    .clock (clk),
    .reset (rst_n),
    .cpu   (cpu_bus),
    .dma   (dma_bus)
`ifdef DMA_SCHED_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int comp_seen = 0;
  int comp_cyc = 0;
  int poll_cnt = 0;
  int busy_polls = 0;
  int irq_cnt = 0;
  int ctrl_cyc = 0;
  int first_poll_cyc = 0;
  int push_cyc = 0;
  bit poll_pend = 1'b0;
  logic stall = 1'b0;
  logic err = 1'b0;
  logic [31:0] up_q [$];
  logic [63:0] wq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [31:0] va(input logic [2:0] sel);
    return {19'd0, sel, 1'b1, 9'd0};
  endfunction

  // DMA model: zero-wait unless stalled; polls report busy busy_polls times, then idle/err.
  assign dma_bus.done   = dma_bus.start & ~stall;
  assign dma_bus.result = (dma_bus.start === 1'b1 && dma_bus.valueA[9] === 1'b0) ?
                          ((poll_cnt < busy_polls) ? 32'h1 : {30'd0, err, 1'b0}) : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dma_bus.start === 1'b1 && dma_bus.done === 1'b1) begin
      if (dma_bus.valueA[9]) poll_cnt <= 0;
      else if (poll_cnt < busy_polls) poll_cnt <= poll_cnt + 1;
      else begin
        comp_seen <= comp_seen + 1;
        comp_cyc  <= cyc + 1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (cpu_bus.done === 1'b1) begin
      if (up_q.size() == 0) begin
        n_chk++;
        $display("FAIL ci_done: unexpected done with result %h, want no response", cpu_bus.result);
      end else begin
        chk("ci_result", {32'd0, cpu_bus.result}, {32'd0, up_q.pop_front()});
      end
    end
    if (dma_bus.start === 1'b1 && dma_bus.done === 1'b1 && dma_bus.valueA[9] === 1'b1) begin
      if (wq.size() == 0) begin
        n_chk++;
        $display("FAIL dma_write: unexpected write %h/%h, want none", dma_bus.valueA, dma_bus.valueB);
      end else begin
        chk("dma_write", {dma_bus.valueA, dma_bus.valueB}, wq.pop_front());
      end
      if (dma_bus.valueA[12:10] == 3'd5) begin
        ctrl_cyc  = cyc;
        poll_pend = 1'b1;
      end
    end
    if (poll_pend && dma_bus.start === 1'b1 && dma_bus.valueA[9] === 1'b0) begin
      first_poll_cyc = cyc;
      poll_pend      = 1'b0;
    end
`ifdef DMA_SCHED_IRQ_EN
    if (irq === 1'b1) irq_cnt++;
`endif
  end

  task automatic ci(input logic [3:0] op, input logic [31:0] b, input logic [31:0] exp);
    cpu_bus.start  = 1'b1;
    cpu_bus.ciN    = 8'h00;
    cpu_bus.valueA = {28'd0, op};
    cpu_bus.valueB = b;
    up_q.push_back(exp);
    @(posedge clk);
    #1;
    cpu_bus.start  = 1'b0;
  endtask

  task automatic exp_job(input logic [31:0] bus, input logic dir);
    wq.push_back({va(3'd1), bus});
    wq.push_back({va(3'd2), 32'h10});
    wq.push_back({va(3'd3), 32'd8});
    wq.push_back({va(3'd4), 32'd3});
    wq.push_back({va(3'd5), dir ? 32'd2 : 32'd1});
  endtask

  task automatic wait_comp(input int target);
    int i;
    i = 0;
    while (comp_seen < target && i < 500) begin
      @(posedge clk);
      i++;
    end
    @(posedge clk);
    #1;
    chk("comp_wait", 64'(comp_seen), 64'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    cpu_bus.start  = 1'b0;
    cpu_bus.ciN    = 8'h00;
    cpu_bus.valueA = 32'd0;
    cpu_bus.valueB = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_dma_start", 64'(dma_bus.start), 64'd0);
    chk("rst_dma_va", 64'(dma_bus.valueA), 64'd0);
    chk("rst_dma_vb", 64'(dma_bus.valueB), 64'd0);
    chk("rst_dma_cin", 64'(dma_bus.ciN), 64'd0);
    ci(4'd5, 32'd0, 32'd0);

    // Single job with latency checks
    busy_polls = 20;
    err = 1'b0;
    ci(4'd0, 32'h1000, 32'd0);
    ci(4'd1, 32'h10, 32'd0);
    ci(4'd2, 32'd8, 32'd0);
    ci(4'd3, 32'd3, 32'd0);
    exp_job(32'h1000, 1'b0);
    ci(4'd4, 32'd0, 32'd1);
    push_cyc = cyc;
    wait_comp(1);
    chk("ctrl_latency", 64'(ctrl_cyc - push_cyc), 64'd5);
    chk("poll_latency", 64'(first_poll_cyc - push_cyc), 64'd9);
    ci(4'd5, 32'd0, 32'h0000_0100);

    // Fill the queue behind a stalled job; the sixth push is rejected
    stall = 1'b1;
    busy_polls = 2;
    for (int i = 0; i < 6; i++) begin
      ci(4'd0, 32'h2000 + i, 32'd0);
      if (i < 5) exp_job(32'h2000 + i, i[0]);
      ci(4'd4, {31'd0, i[0]}, (i < 5) ? 32'd1 : 32'd0);
    end
    ci(4'd5, 32'd0, 32'h0000_0109);
    stall = 1'b0;
    wait_comp(6);
    ci(4'd5, 32'd0, 32'h0000_0600);

    // Error completion
    busy_polls = 3;
    err = 1'b1;
    ci(4'd0, 32'h3000, 32'd0);
    exp_job(32'h3000, 1'b1);
    ci(4'd4, 32'd1, 32'd1);
    wait_comp(7);
    ci(4'd5, 32'd0, 32'h0101_0600);

    // Zero block size is refused
    ci(4'd2, 32'd0, 32'd0);
    ci(4'd4, 32'd0, 32'd0);
    ci(4'd5, 32'd0, 32'h0101_0600);
    ci(4'd2, 32'd8, 32'd0);

    // Clear landing on the completion edge
    err = 1'b0;
    busy_polls = 2;
    ci(4'd0, 32'h5000, 32'd0);
    exp_job(32'h5000, 1'b1);
    ci(4'd4, 32'd1, 32'd1);
    push_cyc = cyc;
    repeat (11) @(posedge clk);
    #1;
    ci(4'd6, 32'd0, 32'd0);
    wait_comp(8);
    chk("clr_comp_edge", 64'(comp_cyc), 64'(push_cyc + 12));
    ci(4'd5, 32'd0, 32'h0000_0100);

    // Flush drops queued jobs but not the in-flight one
    stall = 1'b1;
    ci(4'd0, 32'h4000, 32'd0);
    exp_job(32'h4000, 1'b0);
    ci(4'd4, 32'd0, 32'd1);
    ci(4'd0, 32'h4001, 32'd0);
    ci(4'd4, 32'd0, 32'd1);
    ci(4'd0, 32'h4002, 32'd0);
    ci(4'd4, 32'd0, 32'd1);
    ci(4'd7, 32'd0, 32'd0);
    ci(4'd5, 32'd0, 32'h0000_0101);
    stall = 1'b0;
    wait_comp(9);
    ci(4'd5, 32'd0, 32'h0000_0200);

    // Unknown opcode and a command for another CI number
    ci(4'd9, 32'hFFFF_FFFF, 32'd0);
    cpu_bus.start  = 1'b1;
    cpu_bus.ciN    = 8'h5A;
    cpu_bus.valueA = 32'd5;
    @(posedge clk);
    #1;
    cpu_bus.start  = 1'b0;
    cpu_bus.ciN    = 8'h00;

    // Reset while polling
    busy_polls = 50;
    ci(4'd0, 32'h6000, 32'd0);
    exp_job(32'h6000, 1'b0);
    ci(4'd4, 32'd0, 32'd1);
    ci(4'd4, 32'd0, 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("pre_reset_poll", {31'd0, dma_bus.start, dma_bus.valueA}, {31'd0, 1'b1, 32'h0000_1400});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_start", 64'(dma_bus.start), 64'd0);
    chk("post_reset_va", 64'(dma_bus.valueA), 64'd0);
    ci(4'd5, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("ci_queue_drained", 64'(up_q.size()), 64'd0);
    chk("dma_queue_drained", 64'(wq.size()), 64'd0);
`ifdef DMA_SCHED_IRQ_EN
    chk("irq_pulses", 64'(irq_cnt), 64'd9);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
